ccu_id_remap: RTL and testbench



---
 rtl/ccu_pkg.sv | 14 +
 rtl/ccu_id_remap.sv | 162 ++++++++++++++++
 tb/tb_ccu_id_remap.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccu_pkg.sv
// Shared types and helpers for the CCU ID remapper.
package ccu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ccu_id_remap_state_e;

  // Counter width able to hold 0..max_txns outstanding transactions.
  function automatic int unsigned CcuIdRemapCntWidth(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

endpackage

// File: rtl/ccu_id_remap.sv
// Compresses wide CCU master IDs into a small table-indexed ID space and
// restores the original ID on responses using per-entry outstanding counters.
module ccu_id_remap
  import ccu_pkg::*;
#(
  parameter int unsigned InIdWidth    = 9,
  parameter int unsigned OutIdWidth   = 4,
  parameter int unsigned MaxTxnsPerId = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slv_req_valid_i,
  output logic                  slv_req_ready_o,
  input  logic [InIdWidth-1:0]  slv_req_id_i,
  output logic                  mst_req_valid_o,
  input  logic                  mst_req_ready_i,
  output logic [OutIdWidth-1:0] mst_req_id_o,
  input  logic                  mst_rsp_valid_i,
  output logic                  mst_rsp_ready_o,
  input  logic [OutIdWidth-1:0] mst_rsp_id_i,
  input  logic                  mst_rsp_last_i,
  output logic                  slv_rsp_valid_o,
  input  logic                  slv_rsp_ready_i,
  output logic [InIdWidth-1:0]  slv_rsp_id_o,
  output logic                  busy_o
);

  localparam int unsigned NumEntries = 2 ** OutIdWidth;
  localparam int unsigned CntWidth   = CcuIdRemapCntWidth(MaxTxnsPerId);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxnsPerId);
  localparam logic StIdle = logic'(IDLE);
  localparam logic StHold = logic'(HOLD);

  logic [NumEntries-1:0] valid_q, valid_d;
  logic [CntWidth-1:0]   cnt_q [NumEntries];
  logic [CntWidth-1:0]   cnt_d [NumEntries];
  logic [InIdWidth-1:0]  in_id_q [NumEntries];
  logic                  state_q;
  logic [OutIdWidth-1:0] hold_idx_q;

  logic [NumEntries-1:0] match_oh;
  logic                  match_any, free_any, slot_avail;
  logic [OutIdWidth-1:0] match_idx, free_idx, req_idx;
  logic                  req_hs, rsp_done;

  function automatic logic [OutIdWidth-1:0] onehot_to_bin(input logic [NumEntries-1:0] oh);
    logic [OutIdWidth-1:0] b;
    b = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (oh[i]) b = b | OutIdWidth'(i);
    end
    return b;
  endfunction

  // Index of the lowest cleared bit (trailing-zero count of the inverted vector).
  function automatic logic [OutIdWidth-1:0] first_zero(input logic [NumEntries-1:0] v);
    logic [OutIdWidth-1:0] idx;
    idx = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (!v[i]) idx = OutIdWidth'(i);
    end
    return idx;
  endfunction

  always_comb begin
    for (int i = 0; i < NumEntries; i++) begin
      match_oh[i] = valid_q[i] && (in_id_q[i] == slv_req_id_i);
    end
  end

  assign match_any = |match_oh;
  assign match_idx = onehot_to_bin(match_oh);
  assign free_any  = ~&valid_q;
  assign free_idx  = first_zero(valid_q);

  // While a request is pending the ID stays pinned, even if lower slots free up.
  always_comb begin
    slot_avail = 1'b0;
    req_idx    = '0;
    if (state_q == StHold) begin
      slot_avail = 1'b1;
      req_idx    = hold_idx_q;
    end else if (match_any) begin
      slot_avail = cnt_q[match_idx] < CntMax;
      req_idx    = match_idx;
    end else begin
      slot_avail = free_any;
      req_idx    = free_idx;
    end
  end

  assign mst_req_valid_o = slv_req_valid_i & slot_avail;
  assign slv_req_ready_o = mst_req_ready_i & slot_avail;
  assign mst_req_id_o    = req_idx;
  assign req_hs          = slv_req_valid_i & mst_req_ready_i & slot_avail;

  assign slv_rsp_valid_o = mst_rsp_valid_i;
  assign mst_rsp_ready_o = slv_rsp_ready_i;
  assign slv_rsp_id_o    = in_id_q[mst_rsp_id_i];
  assign rsp_done        = mst_rsp_valid_i & slv_rsp_ready_i & mst_rsp_last_i;

  assign busy_o = |valid_q;

  always_comb begin
    logic inc, dec;
    inc     = 1'b0;
    dec     = 1'b0;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NumEntries; i++) begin
      inc = req_hs && (req_idx == OutIdWidth'(i));
      // A stray last response on an empty counter is ignored so it never wraps.
      dec = rsp_done && (mst_rsp_id_i == OutIdWidth'(i)) && (cnt_q[i] != '0);
      case ({inc, dec})
        2'b10: begin
          cnt_d[i]   = cnt_q[i] + 1'b1;
          valid_d[i] = 1'b1;
        end
        2'b01: begin
          cnt_d[i]   = cnt_q[i] - 1'b1;
          valid_d[i] = (cnt_q[i] != CntWidth'(1));
        end
        2'b11:   valid_d[i] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      state_q    <= StIdle;
      hold_idx_q <= '0;
      for (int i = 0; i < NumEntries; i++) cnt_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      case (state_q)
        StIdle: begin
          if (slv_req_valid_i && slot_avail && !mst_req_ready_i) begin
            state_q    <= StHold;
            hold_idx_q <= req_idx;
          end
        end
        StHold: begin
          if (req_hs) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stored IDs are only meaningful while their entry is valid.
  always_ff @(posedge clk_i) begin
    if (req_hs) in_id_q[req_idx] <= slv_req_id_i;
  end

  a_no_rsp_underflow: assert property (
    @(posedge clk_i) disable iff (rst_i) rsp_done |-> (cnt_q[mst_rsp_id_i] != '0)
  );

endmodule

// File: tb/tb_ccu_id_remap.sv
// Bench for ccu_id_remap: table-driven cycle vectors plus scoreboarded sequences.
module tb_ccu_id_remap;

  logic       clk, rst;
  logic       slv_req_valid, slv_req_ready;
  logic [8:0] slv_req_id;
  logic       mst_req_valid, mst_req_ready;
  logic [3:0] mst_req_id;
  logic       mst_rsp_valid, mst_rsp_ready;
  logic [3:0] mst_rsp_id;
  logic       mst_rsp_last;
  logic       slv_rsp_valid, slv_rsp_ready;
  logic [8:0] slv_rsp_id;
  logic       busy;

  int total = 0;
  int bad   = 0;

  ccu_id_remap #(.InIdWidth(9), .OutIdWidth(4), .MaxTxnsPerId(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .slv_req_valid_i (slv_req_valid),
    .slv_req_ready_o (slv_req_ready),
    .slv_req_id_i    (slv_req_id),
    .mst_req_valid_o (mst_req_valid),
    .mst_req_ready_i (mst_req_ready),
    .mst_req_id_o    (mst_req_id),
    .mst_rsp_valid_i (mst_rsp_valid),
    .mst_rsp_ready_o (mst_rsp_ready),
    .mst_rsp_id_i    (mst_rsp_id),
    .mst_rsp_last_i  (mst_rsp_last),
    .slv_rsp_valid_o (slv_rsp_valid),
    .slv_rsp_ready_i (slv_rsp_ready),
    .slv_rsp_id_o    (slv_rsp_id),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req_v;
    logic [8:0] req_id;
    logic       mst_rdy;
    logic       rsp_v;
    logic [3:0] rsp_id;
    logic       rsp_last;
    logic       rsp_rdy;
    logic       e_mvld;
    logic       e_srdy;
    logic [3:0] e_mid;
    logic [8:0] e_rid;
    logic       e_busy;
  } vec_t;

  typedef struct {
    logic [3:0] slot;
    logic [8:0] id;
  } sb_t;

  vec_t vecs [13];
  sb_t  sbq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    slv_req_valid = 1'b0;
    slv_req_id    = '0;
    mst_req_ready = 1'b0;
    mst_rsp_valid = 1'b0;
    mst_rsp_id    = '0;
    mst_rsp_last  = 1'b0;
    slv_rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mid", mst_req_id, 0);
    step();
    rst = 1'b0;
  endtask

  task automatic sb_push(input logic [3:0] slot, input logic [8:0] id);
    sb_t e;
    e.slot = slot;
    e.id   = id;
    sbq.push_back(e);
  endtask

  // Called at the sampling point of a cycle that presents a response.
  task automatic sb_rsp_cmp(input logic [3:0] slot, input logic last);
    int idx;
    idx = -1;
    for (int i = 0; i < sbq.size(); i++) begin
      if (idx < 0 && sbq[i].slot == slot) idx = i;
    end
    chk("rsp_vld", slv_rsp_valid, 1);
    if (idx < 0) begin
      total++;
      bad++;
      $display("FAIL sb_lookup: no pending txn on slot %0d at %0t", slot, $time);
    end else begin
      chk("rsp_id", slv_rsp_id, sbq[idx].id);
      if (last) sbq.delete(idx);
    end
  endtask

  task automatic req(input logic [8:0] id, input logic [3:0] exp_slot);
    slv_req_valid = 1'b1;
    slv_req_id    = id;
    mst_req_ready = 1'b1;
    @(negedge clk);
    chk("req_srdy", slv_req_ready, 1);
    chk("req_mid", mst_req_id, exp_slot);
    sb_push(exp_slot, id);
    step();
    slv_req_valid = 1'b0;
    mst_req_ready = 1'b0;
  endtask

  task automatic rsp(input logic [3:0] slot, input logic last);
    mst_rsp_valid = 1'b1;
    mst_rsp_id    = slot;
    mst_rsp_last  = last;
    slv_rsp_ready = 1'b1;
    @(negedge clk);
    sb_rsp_cmp(slot, last);
    step();
    mst_rsp_valid = 1'b0;
    mst_rsp_last  = 1'b0;
    slv_rsp_ready = 1'b0;
  endtask

  initial begin
    //           req_v req_id  rdy   rsp_v id    last  rrdy  e_mvld e_srdy e_mid e_rid   e_busy
    vecs[0]  = '{1'b0, 9'h000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 9'h000, 1'b0};
    vecs[1]  = '{1'b1, 9'h1a3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 9'h000, 1'b0};
    vecs[2]  = '{1'b0, 9'h000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 9'h000, 1'b1};
    vecs[3]  = '{1'b0, 9'h000, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 9'h1a3, 1'b1};
    vecs[4]  = '{1'b0, 9'h000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 9'h000, 1'b0};
    vecs[5]  = '{1'b1, 9'h010, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 9'h000, 1'b0};
    vecs[6]  = '{1'b1, 9'h011, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 9'h000, 1'b1};
    vecs[7]  = '{1'b1, 9'h011, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 9'h000, 1'b1};
    vecs[8]  = '{1'b0, 9'h000, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 9'h011, 1'b1};
    vecs[9]  = '{1'b0, 9'h000, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 9'h011, 1'b1};
    vecs[10] = '{1'b0, 9'h000, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 9'h011, 1'b1};
    vecs[11] = '{1'b0, 9'h000, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 9'h010, 1'b1};
    vecs[12] = '{1'b0, 9'h000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 9'h000, 1'b0};

    rst = 1'b1;
    idle_in();
    #1;
    do_reset();

    // Basic map/restore, backpressure on both sides, non-last beats.
    for (int v = 0; v < 13; v++) begin
      slv_req_valid = vecs[v].req_v;
      slv_req_id    = vecs[v].req_id;
      mst_req_ready = vecs[v].mst_rdy;
      mst_rsp_valid = vecs[v].rsp_v;
      mst_rsp_id    = vecs[v].rsp_id;
      mst_rsp_last  = vecs[v].rsp_last;
      slv_rsp_ready = vecs[v].rsp_rdy;
      @(negedge clk);
      chk($sformatf("v%0d_mvld", v), mst_req_valid, vecs[v].e_mvld);
      chk($sformatf("v%0d_srdy", v), slv_req_ready, vecs[v].e_srdy);
      chk($sformatf("v%0d_mid", v), mst_req_id, vecs[v].e_mid);
      chk($sformatf("v%0d_busy", v), busy, vecs[v].e_busy);
      chk($sformatf("v%0d_rvld", v), slv_rsp_valid, vecs[v].rsp_v);
      chk($sformatf("v%0d_rrdy", v), mst_rsp_ready, vecs[v].rsp_rdy);
      if (vecs[v].rsp_v) chk($sformatf("v%0d_rid", v), slv_rsp_id, vecs[v].e_rid);
      step();
    end
    idle_in();

    // Per-ID outstanding limit; other IDs still proceed.
    do_reset();
    for (int i = 0; i < 8; i++) req(9'h005, 4'd0);
    slv_req_valid = 1'b1;
    slv_req_id    = 9'h005;
    mst_req_ready = 1'b1;
    @(negedge clk);
    chk("limit_srdy", slv_req_ready, 0);
    chk("limit_mvld", mst_req_valid, 0);
    step();
    req(9'h006, 4'd1);
    rsp(4'd0, 1'b1);
    req(9'h005, 4'd0);
    for (int i = 0; i < 8; i++) rsp(4'd0, 1'b1);
    rsp(4'd1, 1'b1);
    @(negedge clk);
    chk("limit_busy", busy, 0);
    chk("limit_sb_empty", sbq.size(), 0);
    step();

    // Full table: new ID stalls, including in the cycle slot 5 is freed.
    do_reset();
    for (int i = 0; i < 16; i++) req(9'h100 + 9'(i), 4'(i));
    slv_req_valid = 1'b1;
    slv_req_id    = 9'h1ff;
    mst_req_ready = 1'b1;
    @(negedge clk);
    chk("full_srdy", slv_req_ready, 0);
    chk("full_mvld", mst_req_valid, 0);
    step();
    mst_rsp_valid = 1'b1;
    mst_rsp_id    = 4'd5;
    mst_rsp_last  = 1'b1;
    slv_rsp_ready = 1'b1;
    @(negedge clk);
    chk("full_free_srdy", slv_req_ready, 0);
    sb_rsp_cmp(4'd5, 1'b1);
    step();
    idle_in();
    req(9'h1ff, 4'd5);
    for (int i = 0; i < 16; i++) rsp(4'(i), 1'b1);
    @(negedge clk);
    chk("full_busy", busy, 0);
    step();

    // Pending request keeps its ID while a lower slot frees.
    do_reset();
    req(9'h020, 4'd0);
    req(9'h021, 4'd1);
    req(9'h022, 4'd2);
    slv_req_valid = 1'b1;
    slv_req_id    = 9'h023;
    mst_req_ready = 1'b0;
    @(negedge clk);
    chk("hold_mid0", mst_req_id, 3);
    chk("hold_mvld0", mst_req_valid, 1);
    step();
    mst_rsp_valid = 1'b1;
    mst_rsp_id    = 4'd0;
    mst_rsp_last  = 1'b1;
    slv_rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_mid1", mst_req_id, 3);
    sb_rsp_cmp(4'd0, 1'b1);
    step();
    mst_rsp_valid = 1'b0;
    mst_rsp_last  = 1'b0;
    slv_rsp_ready = 1'b0;
    @(negedge clk);
    chk("hold_mid2", mst_req_id, 3);
    step();
    req(9'h023, 4'd3);
    req(9'h024, 4'd0);
    rsp(4'd3, 1'b1);

    // Same-cycle last response and same-ID request on slot 2.
    do_reset();
    req(9'h030, 4'd0);
    req(9'h031, 4'd1);
    req(9'h032, 4'd2);
    slv_req_valid = 1'b1;
    slv_req_id    = 9'h032;
    mst_req_ready = 1'b1;
    mst_rsp_valid = 1'b1;
    mst_rsp_id    = 4'd2;
    mst_rsp_last  = 1'b1;
    slv_rsp_ready = 1'b1;
    @(negedge clk);
    chk("sim_mid", mst_req_id, 2);
    chk("sim_srdy", slv_req_ready, 1);
    sb_rsp_cmp(4'd2, 1'b1);
    sb_push(4'd2, 9'h032);
    step();
    idle_in();
    slv_req_id = 9'h040;
    @(negedge clk);
    chk("sim_keep_valid", mst_req_id, 3);
    step();
    rsp(4'd2, 1'b1);
    req(9'h040, 4'd2);

    // Asynchronous reset while a request is held with four entries busy.
    do_reset();
    for (int i = 0; i < 4; i++) req(9'h050 + 9'(i), 4'(i));
    slv_req_valid = 1'b1;
    slv_req_id    = 9'h055;
    mst_req_ready = 1'b0;
    @(negedge clk);
    chk("arst_pre_mid", mst_req_id, 4);
    chk("arst_pre_busy", busy, 1);
    step();
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mid", mst_req_id, 0);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    idle_in();
    step();
    chk("arst_post_busy", busy, 0);
    req(9'h055, 4'd0);
    rsp(4'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
